// File: rtl/sram_controller_pkg.sv
// Shared state encoding, widths and default address window for the SRAM controller.
package sram_controller_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned SRAM_AW = 18;
    localparam int unsigned SRAM_DW = 16;

    localparam logic [WORD_W-1:0] DEFAULT_BASE_ADDR = 32'd1024;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    function automatic logic is_hi_half(input state_t s);
        return (s == RD_HI) || (s == WR_HI);
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Counts the cycles spent in one SRAM half; terminal count flags the last cycle of that half.
module sram_wait_counter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tc_c
);

    localparam int unsigned CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    logic [CNT_W-1:0] r_count;

    // Holds at terminal count so a stalled clear can never wrap the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (!o_tc_c) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_tc_c = (r_count == CNT_W'(WAIT_CYCLES));

endmodule

// File: rtl/sram_controller.sv
// Sequences one 32-bit load or store as two 16-bit SRAM halves, stalling the pipeline meanwhile.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [WORD_W-1:0]  ALU_result,
    input  logic [WORD_W-1:0]  Val_Rm,
    output logic               ready,
    output logic [WORD_W-1:0]  read_data,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [SRAM_DW-1:0] SRAM_DQ_out,
    output logic               SRAM_DQ_oe,
    input  logic [SRAM_DW-1:0] SRAM_DQ_in,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    state_t            r_state;
    state_t            w_next_state;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic              w_req;
    logic              w_tc;
    logic              w_clear;
    logic              w_half;
    logic              w_unused_addr;

    assign w_req  = MEM_R_EN | MEM_W_EN;
    assign w_half = is_hi_half(r_state);

    // Only word-aligned accesses within the SRAM window are meaningful.
    assign w_unused_addr = ^{r_addr[WORD_W-1:19], r_addr[1:0]};

    // Each state entry starts a fresh count; outside the halves the counter idles at zero.
    assign w_clear = (w_next_state != r_state) || (r_state == IDLE) || (r_state == DONE);

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .o_tc_c  (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            read_data <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == IDLE) && w_req) begin
                r_addr  <= ALU_result - BASE_ADDR;
                r_wdata <= Val_Rm;
            end
            if ((r_state == RD_LO) && w_tc) begin
                read_data[15:0] <= SRAM_DQ_in;
            end
            if ((r_state == RD_HI) && w_tc) begin
                read_data[31:16] <= SRAM_DQ_in;
            end
        end
    end

    // Next-state and SRAM strobes; WE_N rises on the last cycle of a write half with address/data held.
    always_comb begin
        w_next_state = r_state;
        ready        = 1'b0;
        SRAM_ADDR    = '0;
        SRAM_DQ_out  = '0;
        SRAM_DQ_oe   = 1'b0;
        SRAM_WE_N    = 1'b1;
        SRAM_OE_N    = 1'b1;
        case (r_state)
            IDLE: begin
                ready = !w_req;
                if (MEM_W_EN) begin
                    w_next_state = WR_LO;
                end else if (MEM_R_EN) begin
                    w_next_state = RD_LO;
                end
            end
            RD_LO, RD_HI: begin
                SRAM_ADDR = {r_addr[18:2], w_half};
                SRAM_OE_N = 1'b0;
                if (w_tc) begin
                    w_next_state = (r_state == RD_LO) ? RD_HI : DONE;
                end
            end
            WR_LO, WR_HI: begin
                SRAM_ADDR   = {r_addr[18:2], w_half};
                SRAM_DQ_oe  = 1'b1;
                SRAM_DQ_out = w_half ? r_wdata[31:16] : r_wdata[15:0];
                SRAM_WE_N   = w_tc;
                if (w_tc) begin
                    w_next_state = (r_state == WR_LO) ? WR_HI : DONE;
                end
            end
            DONE: begin
                ready        = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed and random accesses against an SRAM array and a cycle-level expectation model.
`timescale 1ns/1ps
module tb_sram_controller;

    localparam logic [31:0] BASE = 32'd1024;

    typedef struct packed {
        logic        ready;
        logic [17:0] addr;
        logic [15:0] dq;
        logic        dq_oe;
        logic        we_n;
        logic        oe_n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_en;
    logic        w_en;
    logic [31:0] alu;
    logic [31:0] val;

    logic        ready0, dqoe0, we0, oe0, ce0, ub0, lb0;
    logic [31:0] rdata0;
    logic [17:0] addr0;
    logic [15:0] dqo0, dqi0;
    logic        ready1, dqoe1, we1, oe1, ce1, ub1, lb1;
    logic [31:0] rdata1;
    logic [17:0] addr1;
    logic [15:0] dqo1, dqi1;

    logic        bd_en;
    logic [17:0] bd_addr;
    logic [15:0] bd_data;
    logic [15:0] mem0 [0:262143];
    logic [15:0] mem1 [0:262143];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst), .MEM_R_EN(r_en), .MEM_W_EN(w_en), .ALU_result(alu), .Val_Rm(val),
        .ready(ready0), .read_data(rdata0), .SRAM_ADDR(addr0), .SRAM_DQ_out(dqo0), .SRAM_DQ_oe(dqoe0),
        .SRAM_DQ_in(dqi0), .SRAM_WE_N(we0), .SRAM_OE_N(oe0), .SRAM_CE_N(ce0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0)
    );

    sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst), .MEM_R_EN(r_en), .MEM_W_EN(w_en), .ALU_result(alu), .Val_Rm(val),
        .ready(ready1), .read_data(rdata1), .SRAM_ADDR(addr1), .SRAM_DQ_out(dqo1), .SRAM_DQ_oe(dqoe1),
        .SRAM_DQ_in(dqi1), .SRAM_WE_N(we1), .SRAM_OE_N(oe1), .SRAM_CE_N(ce1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
    );

    // Asynchronous SRAM model: writes land while WE_N is low, reads drive while OE_N is low.
    always @(posedge clk) begin
        if (bd_en) begin
            mem0[bd_addr] <= bd_data;
            mem1[bd_addr] <= bd_data;
        end
        if (!we0 && dqoe0) mem0[addr0] <= dqo0;
        if (!we1 && dqoe1) mem1[addr1] <= dqo1;
    end

    assign dqi0 = (oe0 == 1'b0) ? mem0[addr0] : 16'h0000;
    assign dqi1 = (oe1 == 1'b0) ? mem1[addr1] : 16'h0000;

    // Expected pins in cycle k after acceptance: two halves of w+1 cycles, then one ready cycle.
    function automatic exp_t expect_cycle(input int unsigned w, input bit wr, input logic [31:0] byte_addr,
                                          input logic [31:0] wdata, input int unsigned k);
        exp_t        e;
        int unsigned h;
        int unsigned pos;
        bit          hi;
        logic [31:0] word;
        h       = w + 1;
        word    = (byte_addr - BASE) / 4;
        e.ready = 1'b0;
        e.addr  = '0;
        e.dq    = '0;
        e.dq_oe = 1'b0;
        e.we_n  = 1'b1;
        e.oe_n  = 1'b1;
        if (k >= 1 && k <= 2 * h) begin
            hi     = (k > h);
            pos    = hi ? (k - 1 - h) : (k - 1);
            e.addr = 18'(word * 2 + (hi ? 32'd1 : 32'd0));
            if (wr) begin
                e.dq_oe = 1'b1;
                e.dq    = hi ? wdata[31:16] : wdata[15:0];
                e.we_n  = (pos == w);
            end else begin
                e.oe_n = 1'b0;
            end
        end else begin
            e.ready = 1'b1;
        end
        return e;
    endfunction

    // Address is don't-care when no strobe is active; data is don't-care when not driven.
    function automatic exp_t care(input exp_t e, input exp_t o);
        exp_t r;
        r = o;
        if (!e.dq_oe && e.oe_n) r.addr = e.addr;
        if (!e.dq_oe) r.dq = e.dq;
        return r;
    endfunction

    function automatic exp_t obs0();
        exp_t o;
        o.ready = ready0; o.addr = addr0; o.dq = dqo0; o.dq_oe = dqoe0; o.we_n = we0; o.oe_n = oe0;
        return o;
    endfunction

    function automatic exp_t obs1();
        exp_t o;
        o.ready = ready1; o.addr = addr1; o.dq = dqo1; o.dq_oe = dqoe1; o.we_n = we1; o.oe_n = oe1;
        return o;
    endfunction

    task automatic poke(input logic [17:0] a, input logic [15:0] d);
        bd_en = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; r_en = 1'b0; w_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; r_en = 1'b0; w_en = 1'b0; alu = '0; val = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ready0, we0, oe0, dqoe0} !== 4'b1110) begin
            failures++; $display("FAIL reset_pins0: got %b, expected 1110", {ready0, we0, oe0, dqoe0});
        end
        checks++;
        if (rdata0 !== 32'h0) begin failures++; $display("FAIL reset_rdata0: got %h, expected 0", rdata0); end
        checks++;
        if ({ready1, we1, oe1, dqoe1} !== 4'b1110) begin
            failures++; $display("FAIL reset_pins1: got %b, expected 1110", {ready1, we1, oe1, dqoe1});
        end
        checks++;
        if (rdata1 !== 32'h0) begin failures++; $display("FAIL reset_rdata1: got %h, expected 0", rdata1); end
        checks++;
        if ({ce0, ub0, lb0, ce1, ub1, lb1} !== 6'b0) begin
            failures++; $display("FAIL strap_pins: got %b, expected 000000", {ce0, ub0, lb0, ce1, ub1, lb1});
        end
        rst = 1'b0;
    endtask

    task automatic test_store();
        exp_t e, o;
        int   lo_low, hi_low;
        lo_low = 0; hi_low = 0;
        @(negedge clk);
        w_en = 1'b1; r_en = 1'b0; alu = 32'd1028; val = 32'hDEADBEEF;
        #1;
        checks++;
        if (ready0 !== 1'b0) begin failures++; $display("FAIL store_req_stall: got ready=%b, expected 0", ready0); end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            e = expect_cycle(1, 1'b1, 32'd1028, 32'hDEADBEEF, k);
            o = care(e, obs0());
            checks++;
            if (o !== e) begin failures++; $display("FAIL store_cycle%0d: got %h, expected %h", k, o, e); end
            if (!we0) begin
                if (k <= 2) lo_low++;
                else hi_low++;
            end
            w_en = 1'b0;
        end
        checks++;
        if (lo_low != 1 || hi_low != 1) begin
            failures++; $display("FAIL store_we_width: got lo=%0d hi=%0d, expected 1 and 1", lo_low, hi_low);
        end
        checks++;
        if (mem0[2] !== 16'hBEEF || mem0[3] !== 16'hDEAD) begin
            failures++; $display("FAIL store_mem: got %h %h, expected BEEF DEAD", mem0[2], mem0[3]);
        end
    endtask

    task automatic test_load();
        exp_t e, o;
        poke(18'd2, 16'h1234);
        poke(18'd3, 16'hABCD);
        @(negedge clk);
        r_en = 1'b1; w_en = 1'b0; alu = 32'd1028; val = 32'h0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            e = expect_cycle(1, 1'b0, 32'd1028, 32'h0, k);
            o = care(e, obs0());
            checks++;
            if (o !== e) begin failures++; $display("FAIL load_cycle%0d: got %h, expected %h", k, o, e); end
            if (k == 5) begin
                checks++;
                if (rdata0 !== 32'hABCD1234) begin
                    failures++; $display("FAIL load_data: got %h, expected abcd1234", rdata0);
                end
            end
            r_en = 1'b0;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (rdata0 !== 32'hABCD1234) begin failures++; $display("FAIL load_hold: got %h, expected abcd1234", rdata0); end
    endtask

    task automatic test_both();
        exp_t        e, o;
        int          oe_low;
        int unsigned idx;
        logic [31:0] a, d;
        oe_low = 0;
        idx = $urandom_range(16, 255);
        a = BASE + 32'(idx) * 4;
        d = $urandom;
        @(negedge clk);
        r_en = 1'b1; w_en = 1'b1; alu = a; val = d;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            e = expect_cycle(1, 1'b1, a, d, k);
            o = care(e, obs0());
            checks++;
            if (o !== e) begin failures++; $display("FAIL both_cycle%0d: got %h, expected %h", k, o, e); end
            if (!oe0) oe_low++;
            r_en = 1'b0; w_en = 1'b0;
        end
        checks++;
        if (oe_low != 0) begin failures++; $display("FAIL both_oe: got %0d OE_N-low cycles, expected 0", oe_low); end
        checks++;
        if ({mem0[idx*2+1], mem0[idx*2]} !== d) begin
            failures++; $display("FAIL both_mem: got %h, expected %h", {mem0[idx*2+1], mem0[idx*2]}, d);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e, o;
        int   bad;
        bad = 0;
        poke(18'd20, 16'h5A5A);
        poke(18'd21, 16'hC3C3);
        @(negedge clk);
        r_en = 1'b1; w_en = 1'b0; alu = BASE + 32'd40;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            e = expect_cycle(1, 1'b0, BASE + 32'd40, 32'h0, k);
            o = care(e, obs0());
            checks++;
            if (o !== e) begin failures++; $display("FAIL rstmid_cycle%0d: got %h, expected %h", k, o, e); end
            r_en = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ready0, oe0, we0, dqoe0} !== 4'b1110) begin
            failures++; $display("FAIL rstmid_pins: got %b, expected 1110", {ready0, oe0, we0, dqoe0});
        end
        checks++;
        if (rdata0 !== 32'h0) begin failures++; $display("FAIL rstmid_rdata: got %h, expected 0", rdata0); end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (!we0 || !oe0 || dqoe0 || !ready0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL rstmid_quiet: got %0d active cycles, expected 0", bad); end
    endtask

    task automatic test_back_to_back();
        exp_t        e, o;
        logic [31:0] a, d;
        a = BASE + 32'($urandom_range(256, 1023)) * 4 + 32'($urandom_range(0, 3));
        d = $urandom;
        @(negedge clk);
        w_en = 1'b1; r_en = 1'b0; alu = a; val = d;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 6) begin
                checks++;
                if (ready0 !== 1'b0) begin
                    failures++; $display("FAIL b2b_idle_stall: got ready=%b, expected 0", ready0);
                end
            end else begin
                e = (k < 6) ? expect_cycle(1, 1'b1, a, d, k) : expect_cycle(1, 1'b0, a, 32'h0, k - 6);
                o = care(e, obs0());
                checks++;
                if (o !== e) begin failures++; $display("FAIL b2b_cycle%0d: got %h, expected %h", k, o, e); end
            end
            if (k == 11) begin
                checks++;
                if (rdata0 !== d) begin failures++; $display("FAIL b2b_data: got %h, expected %h", rdata0, d); end
            end
            if (k == 5) begin w_en = 1'b0; r_en = 1'b1; end
            if (k == 7) r_en = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [31:0] ref_mem [int];
        exp_t        e, o;
        int          idx;
        bit          wr;
        logic [31:0] a, d;
        for (int n = 0; n < 24; n++) begin
            idx = 2048 + int'($urandom_range(0, 15));
            wr  = ($urandom_range(0, 1) == 1) || !ref_mem.exists(idx);
            a   = BASE + 32'(idx) * 4 + 32'($urandom_range(0, 3));
            d   = $urandom;
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                checks++;
                if (ready0 !== 1'b1) begin failures++; $display("FAIL rand%0d_idle: got ready=%b, expected 1", n, ready0); end
            end
            w_en = wr; r_en = wr ? 1'($urandom_range(0, 1)) : 1'b1; alu = a; val = d;
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                e = expect_cycle(1, wr, a, d, k);
                o = care(e, obs0());
                checks++;
                if (o !== e) begin failures++; $display("FAIL rand%0d_cycle%0d: got %h, expected %h", n, k, o, e); end
                if (k == 5 && !wr) begin
                    checks++;
                    if (rdata0 !== ref_mem[idx]) begin
                        failures++; $display("FAIL rand%0d_data: got %h, expected %h", n, rdata0, ref_mem[idx]);
                    end
                end
                r_en = 1'b0; w_en = 1'b0;
            end
            if (wr) ref_mem[idx] = d;
        end
    endtask

    task automatic test_wait3();
        exp_t        e, o;
        int          first_ready;
        logic [31:0] a, d;
        do_reset();
        a = BASE + 32'($urandom_range(100, 200)) * 4;
        d = $urandom;
        for (int pass = 0; pass < 2; pass++) begin
            first_ready = 0;
            @(negedge clk);
            w_en = (pass == 0); r_en = (pass == 1); alu = a; val = d;
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                e = expect_cycle(3, pass == 0, a, d, k);
                o = care(e, obs1());
                checks++;
                if (o !== e) begin failures++; $display("FAIL w3_pass%0d_cycle%0d: got %h, expected %h", pass, k, o, e); end
                if (ready1 && first_ready == 0) first_ready = k;
                if (k == 9 && pass == 1) begin
                    checks++;
                    if (rdata1 !== d) begin failures++; $display("FAIL w3_data: got %h, expected %h", rdata1, d); end
                end
                r_en = 1'b0; w_en = 1'b0;
            end
            checks++;
            if (first_ready != 9) begin
                failures++; $display("FAIL w3_latency%0d: got %0d, expected 9", pass, first_ready);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by 1000000 ns, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; r_en = 1'b0; w_en = 1'b0; alu = '0; val = '0;
        bd_en = 1'b0; bd_addr = '0; bd_data = '0;
        test_reset();
        test_store();
        test_load();
        test_both();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_wait3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
